// File: rtl/bn128_pkg.sv
// bn128_pkg: field constants for the bn128 curve (operand width and base-field prime).
package bn128_pkg;
    localparam int DAT_BITS = 256;
    localparam logic [DAT_BITS-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
endpackage

// File: rtl/mod_mult_responder_pkg.sv
// mod_mult_responder_pkg: state encoding for the modular-multiply responder.
package mod_mult_responder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/if_axi_stream.sv
// if_axi_stream: valid/ready stream beat with tag, framing and error side-band.
interface if_axi_stream #(
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 16,
    parameter int MOD_BITS = 6
) ();
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] dat;
    modport source (output val, sop, eop, err, mod, ctl, dat, input rdy);
    modport sink (input val, sop, eop, err, mod, ctl, dat, output rdy);
endinterface

// File: rtl/mod_mult_responder_dbl_add.sv
// mod_dbl_add_step: one interleaved multiply step, res = (2*acc + b_bit*a) mod P.
// Inputs must be < P and P < 2^(W-1), so each reduction needs only one conditional subtract.
module mod_dbl_add_step #(
    parameter int W = 256,
    parameter logic [W-1:0] P = bn128_pkg::P
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic         b_bit,
    output logic [W-1:0] res
);
    logic [W:0]   dbl;
    logic [W:0]   sum;
    logic [W-1:0] dbl_r;

    always_comb begin
        dbl   = {acc, 1'b0};
        dbl_r = dbl >= {1'b0, P} ? W'(dbl - {1'b0, P}) : dbl[W-1:0];
        sum   = {1'b0, dbl_r} + (b_bit ? {1'b0, a} : '0);
        res   = sum >= {1'b0, P} ? W'(sum - {1'b0, P}) : sum[W-1:0];
    end
endmodule

// File: rtl/mod_mult_responder.sv
// mod_mult_responder: iterative a*b mod P responder, one request in flight, tag echoed.
// Define MOD_MULT_RESPONDER_RADIX4_EN to consume two multiplier bits per cycle.
module mod_mult_responder
    import mod_mult_responder_pkg::*;
#(
    parameter int DAT_BITS = bn128_pkg::DAT_BITS,
    parameter int CTL_BITS = 16,
    parameter logic [DAT_BITS-1:0] P = bn128_pkg::P
) (
    input logic          i_clk,
    input logic          i_rst_n,
    if_axi_stream.sink   i_mul_if,
    if_axi_stream.source o_mul_if
);
`ifdef MOD_MULT_RESPONDER_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int CNT_W = $clog2(DAT_BITS);

    state_e              state_q, state_d;
    logic [DAT_BITS-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, step_res;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                hs_in, hs_out, last;
    logic                unused_sink;

    assign unused_sink = ^{i_mul_if.sop, i_mul_if.eop, i_mul_if.err, i_mul_if.mod};
    assign hs_in  = i_mul_if.val && rdy_q;
    assign hs_out = (state_q == DONE) && o_mul_if.rdy;
    assign last   = cnt_q == CNT_W'(STEP - 1);

`ifdef MOD_MULT_RESPONDER_RADIX4_EN
    logic [DAT_BITS-1:0] res_mid;
    mod_dbl_add_step #(.W(DAT_BITS), .P(P)) u_step_hi (
        .acc(acc_q), .a(a_q), .b_bit(b_q[cnt_q]), .res(res_mid)
    );
    mod_dbl_add_step #(.W(DAT_BITS), .P(P)) u_step_lo (
        .acc(res_mid), .a(a_q), .b_bit(b_q[cnt_q - CNT_W'(1)]), .res(step_res)
    );
`else
    mod_dbl_add_step #(.W(DAT_BITS), .P(P)) u_step (
        .acc(acc_q), .a(a_q), .b_bit(b_q[cnt_q]), .res(step_res)
    );
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (hs_in ? BUSY : IDLE) :
                  state_q == BUSY ? (last ? DONE : BUSY) :
                  (hs_out ? IDLE : DONE);
        a_d     = hs_in ? i_mul_if.dat[DAT_BITS-1:0] : a_q;
        b_d     = hs_in ? i_mul_if.dat[2*DAT_BITS-1:DAT_BITS] : b_q;
        ctl_d   = hs_in ? i_mul_if.ctl : ctl_q;
        acc_d   = hs_in ? '0 : state_q == BUSY ? step_res : acc_q;
        cnt_d   = hs_in ? CNT_W'(DAT_BITS - 1) :
                  (state_q == BUSY && !last) ? cnt_q - CNT_W'(STEP) : cnt_q;
        // Registered ready keeps rdy low through reset and drops it in the handshake cycle's successor.
        rdy_d   = state_d == IDLE;
    end

    always_comb begin
        i_mul_if.rdy = rdy_q;
        o_mul_if.val = state_q == DONE;
        o_mul_if.dat = acc_q;
        o_mul_if.ctl = ctl_q;
        o_mul_if.sop = 1'b1;
        o_mul_if.eop = 1'b1;
        o_mul_if.err = 1'b0;
        o_mul_if.mod = '0;
    end

`ifndef SYNTHESIS
    a_operands_reduced: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        hs_in |-> (i_mul_if.dat[DAT_BITS-1:0] < P && i_mul_if.dat[2*DAT_BITS-1:DAT_BITS] < P));
`endif
endmodule

// File: tb/tb_mod_mult_responder.sv
// tb_mod_mult_responder: scoreboard bench for mod_mult_responder against a software a*b%P model.
// Honours MOD_MULT_RESPONDER_RADIX4_EN for the expected latency.
module tb_mod_mult_responder;
    import bn128_pkg::*;

    localparam int DW = 256;
    localparam int CW = 16;
`ifdef MOD_MULT_RESPONDER_RADIX4_EN
    localparam int LAT = DW / 2 + 1;
`else
    localparam int LAT = DW + 1;
`endif

    typedef struct {
        logic [DW-1:0] dat;
        logic [CW-1:0] ctl;
        int            hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_pct = 100;
    int   hold_req = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    if_axi_stream #(.DAT_BITS(2*DW), .CTL_BITS(CW)) req_if ();
    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) rsp_if ();

    mod_mult_responder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mul_if(req_if),
        .o_mul_if(rsp_if)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return DW'(prod % {{DW{1'b0}}, P});
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
        return r;
    endfunction

    // Junk beats are offered while rdy is low; only the beat seen with rdy high is the real request.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] t);
        exp_t e;
        bit   done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            req_if.val = 1'b1;
            if (req_if.rdy) begin
                req_if.dat = {b, a};
                req_if.ctl = t;
                e = '{dat: mulmod(a, b), ctl: t, hs: cyc};
                q.push_back(e);
                done = 1;
            end else begin
                req_if.dat = {rnd(), rnd()};
                req_if.ctl = CW'($urandom());
            end
        end
        check("req_handshake", DW'(done), 1);
        @(posedge clk);
        #1 req_if.val = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 5000 && q.size() != 0; k++) @(negedge clk);
        check("drain", DW'(q.size()), 0);
    endtask

    initial begin : monitor
        exp_t          e;
        logic          prev_val = 0, prev_rdy = 0, rdy, chk_in_rdy = 0;
        logic [DW-1:0] prev_dat = '0;
        logic [CW-1:0] prev_ctl = '0;
        int            hold_left = 0;
        rsp_if.rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_val = 0;
                chk_in_rdy = 0;
                hold_left = 0;
                rsp_if.rdy = 1'b0;
            end else begin
                if (chk_in_rdy) check("in_rdy_after_rsp", DW'(req_if.rdy), 1);
                chk_in_rdy = 0;
                if (prev_val && !prev_rdy) begin
                    check("val_hold", DW'(rsp_if.val), 1);
                    check("dat_stable", rsp_if.dat, prev_dat);
                    check("ctl_stable", DW'(rsp_if.ctl), DW'(prev_ctl));
                end
                if (rsp_if.val) begin
                    check("in_rdy_low", DW'(req_if.rdy), 0);
                    if (q.size() == 0) check("unexpected_val", DW'(rsp_if.val), 0);
                    else if (!prev_val) check("latency", DW'(cyc - q[0].hs), DW'(LAT));
                    if (!prev_val) hold_left = hold_req;
                end
                if (rsp_if.val && hold_left > 0) begin
                    rdy = 1'b0;
                    hold_left--;
                end else rdy = $urandom_range(99) < rdy_pct;
                rsp_if.rdy = rdy;
                if (rsp_if.val && rdy && q.size() != 0) begin
                    e = q.pop_front();
                    check("dat", rsp_if.dat, e.dat);
                    check("ctl", DW'(rsp_if.ctl), DW'(e.ctl));
                    chk_in_rdy = 1;
                end
                prev_val = rsp_if.val;
                prev_rdy = rdy;
                prev_dat = rsp_if.dat;
                prev_ctl = rsp_if.ctl;
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] pm1, half, a, b;
        pm1  = P - 1;
        half = (P + 1) / 2;
        req_if.val = 1'b0;
        req_if.dat = '0;
        req_if.ctl = '0;
        req_if.sop = 1'b1;
        req_if.eop = 1'b1;
        req_if.err = 1'b0;
        req_if.mod = '0;
        repeat (3) @(negedge clk);
        check("rst_out_val", DW'(rsp_if.val), 0);
        check("rst_out_dat", rsp_if.dat, 0);
        check("rst_out_ctl", DW'(rsp_if.ctl), 0);
        check("rst_in_rdy", DW'(req_if.rdy), 0);
        rst_n = 1'b1;
        #1 check("in_rdy_at_release", DW'(req_if.rdy), 0);
        @(negedge clk);
        check("in_rdy_after_release", DW'(req_if.rdy), 1);

        send(3, 2, 16'h00A5);
        drain();
        send(pm1, pm1, 16'h1111);
        send(2, half, 16'h2222);
        send(0, pm1, 16'h0001);
        send(pm1, 0, 16'h0002);
        drain();

        hold_req = 50;
        send(rnd() % P, rnd() % P, 16'h0050);
        drain();
        hold_req = 0;

        send(9, 11, 16'h0BAD);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out_val", DW'(rsp_if.val), 0);
        check("midrst_out_dat", rsp_if.dat, 0);
        check("midrst_in_rdy", DW'(req_if.rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DW + 10) @(negedge clk);
        send(5, 7, 16'h0057);
        drain();

        rdy_pct = 50;
        for (int i = 0; i < 150; i++) begin
            a = rnd() % P;
            b = rnd() % P;
            send(a, b, CW'($urandom()));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
